// File: rtl/touch_adc_spi_ctrl.sv
// SPI controller for an AD7843-style touch ADC: debounced pen detection, X/Y conversion pairs, 12-bit results.
// Optional build macro TOUCH_AVG4_EN: average four valid pairs per dataReady strobe.
module touch_adc_spi_ctrl #(
   parameter int CLK_DIV      = 25,
   parameter int PEN_DEBOUNCE = 1000,
   parameter int SAMPLE_GAP   = 50000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        iPENIRQ_n,
   input  logic        iADC_DOUT,
   input  logic        iADC_BUSY,
   output logic        oADC_CS_n,
   output logic        oADC_DCLK,
   output logic        oADC_DIN,
   output logic [11:0] oREG_X,
   output logic [11:0] oREG_Y,
   output logic        dataReady
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DEB_W = (PEN_DEBOUNCE > 1) ? $clog2(PEN_DEBOUNCE) : 1;
   localparam int GAP_W = (SAMPLE_GAP > 0) ? $clog2(SAMPLE_GAP + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(PEN_DEBOUNCE - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [7:0]       CMD_X    = 8'h90;
   localparam logic [7:0]       CMD_Y    = 8'hD0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      START    = 3'd2,
      SHIFT    = 3'd3,
      GAP      = 3'd4,
      DONE     = 3'd5,
      WAIT     = 3'd6
   } state_t;

   state_t           state_r;
   logic             channel_r;
   logic [DIV_W-1:0] div_r;
   logic [DEB_W-1:0] deb_r;
   logic [GAP_W-1:0] gap_r;
   logic [4:0]       bit_r;
   logic             phase_hi_r;
   logic [11:0]      shift_r;
   logic [11:0]      x_res_r;
   logic             pen_ok_r;
   logic             pen_meta_r, pen_sync_r, dout_meta_r, dout_sync_r;
   logic [7:0]       cmd_s;
   logic             din_next_s;
   logic             div_end_s;
   logic             sample_s;
   logic             pair_valid_s;
   logic             busy_unused_s;

`ifdef TOUCH_AVG4_EN
   logic [13:0] sum_x_r, sum_y_r;
   logic [1:0]  pair_r;
   logic [13:0] sum_x_next_s, sum_y_next_s;
   assign sum_x_next_s = sum_x_r + {2'b00, x_res_r};
   assign sum_y_next_s = sum_y_r + {2'b00, shift_r};
`endif

   assign busy_unused_s = iADC_BUSY;
   assign cmd_s         = channel_r ? CMD_Y : CMD_X;
   assign div_end_s     = (div_r == DIV_LAST);
   // data bits arrive on DCLK rising edges 10..21; captured at the end of each high half
   assign sample_s      = (bit_r >= 5'd9) && (bit_r <= 5'd20);
   assign pair_valid_s  = pen_ok_r && !pen_sync_r;

   // next DIN bit presented at the falling edge that closes period bit_r
   always_comb begin
      din_next_s = 1'b0;
      if (bit_r < 5'd7) begin
         din_next_s = cmd_s[3'd6 - bit_r[2:0]];
      end else begin
         din_next_s = 1'b0;
      end
   end

   // two-flop synchronisers for the asynchronous ADC inputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pen_meta_r  <= 1'b1;
         pen_sync_r  <= 1'b1;
         dout_meta_r <= 1'b0;
         dout_sync_r <= 1'b0;
      end else begin
         pen_meta_r  <= iPENIRQ_n;
         pen_sync_r  <= pen_meta_r;
         dout_meta_r <= iADC_DOUT;
         dout_sync_r <= dout_meta_r;
      end
   end

   // conversion sequencer with registered SPI and result outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         channel_r  <= 1'b0;
         div_r      <= '0;
         deb_r      <= '0;
         gap_r      <= '0;
         bit_r      <= 5'd0;
         phase_hi_r <= 1'b0;
         shift_r    <= 12'd0;
         x_res_r    <= 12'd0;
         pen_ok_r   <= 1'b0;
         oADC_CS_n  <= 1'b1;
         oADC_DCLK  <= 1'b0;
         oADC_DIN   <= 1'b0;
         oREG_X     <= 12'd0;
         oREG_Y     <= 12'd0;
         dataReady  <= 1'b0;
`ifdef TOUCH_AVG4_EN
         sum_x_r    <= 14'd0;
         sum_y_r    <= 14'd0;
         pair_r     <= 2'd0;
`endif
      end else begin
         dataReady <= 1'b0;
         if ((state_r == START || state_r == SHIFT || state_r == GAP) && pen_sync_r) begin
            pen_ok_r <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               oADC_CS_n <= 1'b1;
               oADC_DCLK <= 1'b0;
               oADC_DIN  <= 1'b0;
               if (!pen_sync_r) begin
                  state_r <= DEBOUNCE;
                  deb_r   <= DEB_ONE;
               end
            end
            DEBOUNCE: begin
               if (pen_sync_r) begin
                  state_r <= IDLE;
                  deb_r   <= '0;
               end else if (deb_r >= DEB_LAST) begin
                  state_r   <= START;
                  channel_r <= 1'b0;
                  div_r     <= '0;
                  pen_ok_r  <= 1'b1;
                  shift_r   <= 12'd0;
                  oADC_CS_n <= 1'b0;
                  oADC_DCLK <= 1'b0;
                  oADC_DIN  <= CMD_X[7];
               end else begin
                  deb_r <= deb_r + DEB_ONE;
               end
            end
            START: begin
               if (div_end_s) begin
                  div_r      <= '0;
                  bit_r      <= 5'd0;
                  phase_hi_r <= 1'b1;
                  oADC_DCLK  <= 1'b1;
                  state_r    <= SHIFT;
               end else begin
                  div_r <= div_r + DIV_ONE;
               end
            end
            SHIFT: begin
               if (!div_end_s) begin
                  div_r <= div_r + DIV_ONE;
               end else begin
                  div_r <= '0;
                  if (phase_hi_r) begin
                     if (sample_s) begin
                        shift_r <= {shift_r[10:0], dout_sync_r};
                     end
                     oADC_DCLK  <= 1'b0;
                     oADC_DIN   <= din_next_s;
                     phase_hi_r <= 1'b0;
                  end else if (bit_r != 5'd23) begin
                     oADC_DCLK  <= 1'b1;
                     phase_hi_r <= 1'b1;
                     bit_r      <= bit_r + 5'd1;
                  end else if (!channel_r) begin
                     x_res_r   <= shift_r;
                     oADC_CS_n <= 1'b1;
                     oADC_DIN  <= 1'b0;
                     state_r   <= GAP;
                  end else begin
                     // results are loaded on entry so they are valid during the DONE-cycle strobe
                     oADC_CS_n <= 1'b1;
                     oADC_DIN  <= 1'b0;
                     state_r   <= DONE;
`ifdef TOUCH_AVG4_EN
                     if (pair_valid_s) begin
                        if (pair_r == 2'd3) begin
                           oREG_X    <= sum_x_next_s[13:2];
                           oREG_Y    <= sum_y_next_s[13:2];
                           dataReady <= 1'b1;
                           sum_x_r   <= 14'd0;
                           sum_y_r   <= 14'd0;
                           pair_r    <= 2'd0;
                        end else begin
                           sum_x_r <= sum_x_next_s;
                           sum_y_r <= sum_y_next_s;
                           pair_r  <= pair_r + 2'd1;
                        end
                     end else begin
                        sum_x_r <= 14'd0;
                        sum_y_r <= 14'd0;
                        pair_r  <= 2'd0;
                     end
`else
                     if (pair_valid_s) begin
                        oREG_X    <= x_res_r;
                        oREG_Y    <= shift_r;
                        dataReady <= 1'b1;
                     end
`endif
                  end
               end
            end
            GAP: begin
               if (div_end_s) begin
                  div_r     <= '0;
                  channel_r <= 1'b1;
                  shift_r   <= 12'd0;
                  oADC_CS_n <= 1'b0;
                  oADC_DIN  <= CMD_Y[7];
                  state_r   <= START;
               end else begin
                  div_r <= div_r + DIV_ONE;
               end
            end
            DONE: begin
               gap_r   <= '0;
               state_r <= WAIT;
            end
            WAIT: begin
               if (gap_r != GAP_LAST) begin
                  gap_r <= gap_r + GAP_ONE;
               end else if (!pen_sync_r) begin
                  state_r   <= START;
                  channel_r <= 1'b0;
                  div_r     <= '0;
                  pen_ok_r  <= 1'b1;
                  shift_r   <= 12'd0;
                  oADC_CS_n <= 1'b0;
                  oADC_DCLK <= 1'b0;
                  oADC_DIN  <= CMD_X[7];
               end else begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               oADC_CS_n <= 1'b1;
               oADC_DCLK <= 1'b0;
               oADC_DIN  <= 1'b0;
            end
         endcase
      end
   end
endmodule
